// File: rtl/bht_update_queue.sv
// Branch-outcome FIFO between MEM-stage resolution and the global BHT write port,
// plus saturating branch / misprediction counters for performance monitoring.
module bht_update_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        resolve_valid,
  input  logic [15:0] resolve_pc,
  input  logic        resolve_taken,
  input  logic        resolve_predicted,
  input  logic        hold,
  output logic        write,
  output logic [15:0] write_pc,
  output logic        taken,
  output logic        full,
  output logic        overflow,
  output logic [15:0] branch_count,
  output logic [15:0] mispredict_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [16:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          accept;
  logic          drop;

  // Head is always visible; write only qualifies it, so no enqueue bypass exists.
  assign write    = (count != '0) && !hold;
  assign write_pc = mem[rd_ptr][16:1];
  assign taken    = mem[rd_ptr][0];
  assign full     = (count == DEPTH_CNT);

  assign accept = resolve_valid && ((count < DEPTH_CNT) || write);
  assign drop   = resolve_valid && !accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      count            <= '0;
      overflow         <= 1'b0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= {resolve_pc, resolve_taken};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (write) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({accept, write})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
      if (resolve_valid && (branch_count != '1)) begin
        branch_count <= branch_count + 16'd1;
      end
      if (resolve_valid && (resolve_taken != resolve_predicted) && (mispredict_count != '1)) begin
        mispredict_count <= mispredict_count + 16'd1;
      end
    end
  end

endmodule
